bcd_countdown_timer: RTL



---
 rtl/bcd_countdown_timer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// Four-digit MM:SS BCD down-counter with load/start/pause control and a
// terminal-count pulse. Every output comes straight from a register.
module bcd_countdown_timer #(
    parameter int SEC_T_MAX = 5,
    parameter int DIG_MAX   = 9
) (
    input  logic       clk1,
    input  logic       clear,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] preset_mt,
    input  logic [3:0] preset_mu,
    input  logic [3:0] preset_st,
    input  logic [3:0] preset_su,
    output logic [3:0] q_mt,
    output logic [3:0] q_mu,
    output logic [3:0] q_st,
    output logic [3:0] q_su,
    output logic       running,
    output logic       expired,
    output logic       done
);
    localparam logic [3:0] L_ST_MAX  = 4'(SEC_T_MAX);
    localparam logic [3:0] L_DIG_MAX = 4'(DIG_MAX);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     r_state;
    logic [3:0] r_mt, r_mu, r_st, r_su;
    logic       r_running, r_expired, r_done;

    logic [3:0] w_ld_mt, w_ld_mu, w_ld_st, w_ld_su;
    logic [3:0] w_dec_mt, w_dec_mu, w_dec_st, w_dec_su;
    logic       w_b_su, w_b_st, w_b_mu;
    logic       w_is_zero, w_is_one;

    assign w_ld_mt = (preset_mt > L_DIG_MAX) ? L_DIG_MAX : preset_mt;
    assign w_ld_mu = (preset_mu > L_DIG_MAX) ? L_DIG_MAX : preset_mu;
    assign w_ld_st = (preset_st > L_ST_MAX)  ? L_ST_MAX  : preset_st;
    assign w_ld_su = (preset_su > L_DIG_MAX) ? L_DIG_MAX : preset_su;

    // Borrow ripples units-up; each digit only moves when everything below it wrapped.
    assign w_b_su   = (r_su == 4'd0);
    assign w_b_st   = w_b_su && (r_st == 4'd0);
    assign w_b_mu   = w_b_st && (r_mu == 4'd0);
    assign w_dec_su = w_b_su ? L_DIG_MAX : r_su - 4'd1;
    assign w_dec_st = !w_b_su ? r_st : ((r_st == 4'd0) ? L_ST_MAX  : r_st - 4'd1);
    assign w_dec_mu = !w_b_st ? r_mu : ((r_mu == 4'd0) ? L_DIG_MAX : r_mu - 4'd1);
    assign w_dec_mt = w_b_mu ? r_mt - 4'd1 : r_mt;

    assign w_is_zero = ({r_mt, r_mu, r_st, r_su} == 16'h0000);
    assign w_is_one  = ({r_mt, r_mu, r_st, r_su} == 16'h0001);

    always_ff @(posedge clk1) begin
        if (!clear) begin
            r_state   <= IDLE;
            r_mt      <= 4'd0;
            r_mu      <= 4'd0;
            r_st      <= 4'd0;
            r_su      <= 4'd0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_mt      <= w_ld_mt;
                r_mu      <= w_ld_mu;
                r_st      <= w_ld_st;
                r_su      <= w_ld_su;
                r_state   <= IDLE;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // pause outranks start, so a simultaneous pause blocks the launch
                        if (!pause && start && !w_is_zero) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            r_state   <= PAUSE;
                            r_running <= 1'b0;
                        end else if (tick) begin
                            r_mt <= w_dec_mt;
                            r_mu <= w_dec_mu;
                            r_st <= w_dec_st;
                            r_su <= w_dec_su;
                            if (w_is_one) begin
                                r_state   <= DONE;
                                r_running <= 1'b0;
                                r_expired <= 1'b1;
                                r_done    <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!pause && start) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign q_mt    = r_mt;
    assign q_mu    = r_mu;
    assign q_st    = r_st;
    assign q_su    = r_su;
    assign running = r_running;
    assign expired = r_expired;
    assign done    = r_done;
endmodule
